// File: rtl/m_ctrl_fsm.sv
// m_ctrl_fsm
//   Multicycle control unit for the MIPS-subset CPU. Decodes the instruction
//   register and walks the datapath through fetch, decode, execute, memory and
//   write-back, producing one control word per cycle. Memory states wait for
//   MIO_ready.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low reset (0 = reset on the edge)
//   MIO_ready      memory/IO transfer complete this cycle
//   Inst[31:0]     IR contents; opcode Inst[31:26], funct Inst[5:0]
//   zero           combinational ALU zero flag
//   IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch
//                  single-bit datapath controls
//   RegDst, MemtoReg, ALUSrcB, PCSource
//                  2-bit datapath selects
//   ALU_operation  4-bit ALU op code
//   MemRead, MemWrite, CPU_MIO
//                  memory strobes; CPU_MIO = MemRead | MemWrite | fetch state
//   state[4:0]     current state code, for debug
module m_ctrl_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        MIO_ready,
    input  logic [31:0] Inst,
    input  logic        zero,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [3:0]  ALU_operation,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        CPU_MIO,
    output logic [4:0]  state
);

    localparam logic [4:0] S_IF     = 5'd0;
    localparam logic [4:0] S_ID     = 5'd1;
    localparam logic [4:0] S_MEMADR = 5'd2;
    localparam logic [4:0] S_MEMRD  = 5'd3;
    localparam logic [4:0] S_WBLW   = 5'd4;
    localparam logic [4:0] S_MEMWR  = 5'd5;
    localparam logic [4:0] S_EXR    = 5'd6;
    localparam logic [4:0] S_WBR    = 5'd7;
    localparam logic [4:0] S_BR     = 5'd8;
    localparam logic [4:0] S_J      = 5'd9;
    localparam logic [4:0] S_EXI    = 5'd10;
    localparam logic [4:0] S_WBI    = 5'd11;
    localparam logic [4:0] S_JAL    = 5'd12;
    localparam logic [4:0] S_LUI    = 5'd13;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [4:0] state_q;
    logic [4:0] state_nxt;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_inst_bits;

    assign opcode = Inst[31:26];
    assign funct  = Inst[5:0];
    // Register/immediate fields belong to the datapath, not to control.
    assign unused_inst_bits = ^Inst[25:6];

    // Unrecognised funct codes fall back to ADD.
    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b100110: funct_alu = ALU_XOR;
            6'b100111: funct_alu = ALU_NOR;
            6'b101010: funct_alu = ALU_SLT;
            6'b000010: funct_alu = ALU_SRL;
            default:   funct_alu = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IF;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IF;
        case (state_q)
            S_IF:     state_nxt = MIO_ready ? S_ID : S_IF;
            S_ID: begin
                case (opcode)
                    OP_LW, OP_SW:     state_nxt = S_MEMADR;
                    OP_R:             state_nxt = S_EXR;
                    OP_BEQ, OP_BNE:   state_nxt = S_BR;
                    OP_J:             state_nxt = S_J;
                    OP_JAL:           state_nxt = S_JAL;
                    OP_ADDI, OP_SLTI: state_nxt = S_EXI;
                    OP_LUI:           state_nxt = S_LUI;
                    default:          state_nxt = S_IF;
                endcase
            end
            S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_nxt = MIO_ready ? S_WBLW : S_MEMRD;
            S_MEMWR:  state_nxt = MIO_ready ? S_IF : S_MEMWR;
            S_EXR:    state_nxt = S_WBR;
            S_EXI:    state_nxt = S_WBI;
            default:  state_nxt = S_IF;
        endcase
    end

    // Outputs are a Moore decode of state_q, except IF IRWrite (MIO_ready) and
    // bne PCWrite (zero). Holding reset low forces the whole word to zero at
    // once, so an in-flight write is dropped without waiting for the edge.
    always_comb begin
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        Branch        = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        ALU_operation = ALU_AND;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        CPU_MIO       = 1'b0;
        state         = 5'd0;
        if (reset) begin
            case (state_q)
                S_IF: begin
                    MemRead       = 1'b1;
                    ALUSrcA       = 1'b1;
                    ALUSrcB       = 2'b01;
                    ALU_operation = ALU_ADD;
                    PCWrite       = 1'b1;
                    IRWrite       = MIO_ready;
                end
                S_ID: begin
                    ALUSrcA       = 1'b1;
                    ALUSrcB       = 2'b11;
                    ALU_operation = ALU_ADD;
                end
                S_MEMADR: begin
                    ALUSrcB       = 2'b10;
                    ALU_operation = ALU_ADD;
                end
                // Address ALU controls stay up so ALUOut keeps the address.
                S_MEMRD: begin
                    IorD          = 1'b1;
                    MemRead       = 1'b1;
                    ALUSrcB       = 2'b10;
                    ALU_operation = ALU_ADD;
                end
                S_WBLW: begin
                    MemtoReg = 2'b01;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    IorD          = 1'b1;
                    MemWrite      = 1'b1;
                    ALUSrcB       = 2'b10;
                    ALU_operation = ALU_ADD;
                end
                S_EXR:    ALU_operation = funct_alu(funct);
                S_WBR: begin
                    RegDst   = 2'b01;
                    RegWrite = 1'b1;
                end
                S_BR: begin
                    ALU_operation = ALU_SUB;
                    PCSource      = 2'b01;
                    if (opcode == OP_BNE) begin
                        PCWrite = ~zero;
                    end else begin
                        PCWriteCond = 1'b1;
                        Branch      = 1'b1;
                    end
                end
                S_J: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                end
                S_EXI: begin
                    ALUSrcB       = 2'b10;
                    ALU_operation = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                end
                S_WBI:    RegWrite = 1'b1;
                // PC_Current already holds PC+4, which is what lands in $31.
                S_JAL: begin
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                    RegWrite = 1'b1;
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                end
                S_LUI: begin
                    MemtoReg = 2'b11;
                    RegWrite = 1'b1;
                end
                default: ;
            endcase
            CPU_MIO = MemRead | MemWrite | (state_q == S_IF);
            state   = state_q;
        end
    end

endmodule

// File: tb/tb_m_ctrl_fsm.sv
module tb_m_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MIO_ready = 1'b1;
    logic [31:0] Inst = 32'd0;
    logic        zero = 1'b0;
    logic        IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [3:0]  ALU_operation;
    logic        MemRead, MemWrite, CPU_MIO;
    logic [4:0]  state;

    always #5 clk = ~clk;

    m_ctrl_fsm dut (
        .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .Inst(Inst), .zero(zero),
        .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALU_operation(ALU_operation), .MemRead(MemRead), .MemWrite(MemWrite),
        .CPU_MIO(CPU_MIO), .state(state)
    );

    // Phase identifiers carry the documented debug state codes.
    localparam logic [4:0] P_IF = 0, P_ID = 1, P_MEMADR = 2, P_MEMRD = 3, P_WBLW = 4,
                           P_MEMWR = 5, P_EXR = 6, P_WBR = 7, P_BR = 8, P_J = 9,
                           P_EXI = 10, P_WBI = 11, P_JAL = 12, P_LUI = 13;

    logic [26:0] exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc_no = 0;
    logic        force_z = 1'b0;
    logic        force_z_val = 1'b0;

    function automatic logic [26:0] pack(input logic [4:0] st, input logic iord, irw, rw, asa,
                                         pcw, pcwc, br, input logic [1:0] rd, m2r, asb, pcs,
                                         input logic [3:0] alu, input logic mr, mw);
        return {st, iord, irw, rw, asa, pcw, pcwc, br, rd, m2r, asb, pcs, alu, mr, mw,
                mr | mw | (st == 5'd0)};
    endfunction

    function automatic logic [3:0] ref_funct(input logic [5:0] f);
        case (f)
            6'h20: return 4'd2;  6'h22: return 4'd6;  6'h24: return 4'd0;  6'h25: return 4'd1;
            6'h26: return 4'd3;  6'h27: return 4'd4;  6'h2A: return 4'd7;  6'h02: return 4'd5;
            default: return 4'd2;
        endcase
    endfunction

    // Expected control word for one cycle spent in phase ph.
    function automatic logic [26:0] model(input logic [4:0] ph, input logic [31:0] ins,
                                          input logic mio, input logic z, input logic rst_n);
        logic [5:0] op;
        op = ins[31:26];
        if (!rst_n) return 27'd0;
        case (ph)
            P_IF:     return pack(ph, 0, mio, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd1, 2'd0, 4'd2, 1, 0);
            P_ID:     return pack(ph, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd3, 2'd0, 4'd2, 0, 0);
            P_MEMADR: return pack(ph, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 2'd0, 4'd2, 0, 0);
            P_MEMRD:  return pack(ph, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 2'd0, 4'd2, 1, 0);
            P_WBLW:   return pack(ph, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd0, 4'd0, 0, 0);
            P_MEMWR:  return pack(ph, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 2'd0, 4'd2, 0, 1);
            P_EXR:    return pack(ph, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0,
                                  ref_funct(ins[5:0]), 0, 0);
            P_WBR:    return pack(ph, 0, 0, 1, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 4'd0, 0, 0);
            P_BR:     if (op == 6'b000101)
                          return pack(ph, 0, 0, 0, 0, !z, 0, 0, 2'd0, 2'd0, 2'd0, 2'd1, 4'd6, 0, 0);
                      else
                          return pack(ph, 0, 0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0, 2'd1, 4'd6, 0, 0);
            P_J:      return pack(ph, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd2, 4'd0, 0, 0);
            P_EXI:    return pack(ph, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 2'd0,
                                  (op == 6'b001010) ? 4'd7 : 4'd2, 0, 0);
            P_WBI:    return pack(ph, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 0, 0);
            P_JAL:    return pack(ph, 0, 0, 1, 0, 1, 0, 0, 2'd2, 2'd2, 2'd0, 2'd2, 4'd0, 0, 0);
            P_LUI:    return pack(ph, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd3, 2'd0, 2'd0, 4'd0, 0, 0);
            default:  return 27'd0;
        endcase
    endfunction

    // One clock cycle of stimulus; the expected word goes to the scoreboard.
    task automatic cyc(input logic [4:0] ph, input logic mio, input logic rst_n,
                       input logic [31:0] ins);
        @(posedge clk);
        #1;
        reset     = rst_n;
        MIO_ready = mio;
        Inst      = ins;
        zero      = force_z ? force_z_val : 1'($urandom_range(0, 1));
        exp_q.push_back(model(ph, ins, mio, zero, rst_n));
    endtask

    // Phases an instruction visits after fetch and decode.
    task automatic phases(input logic [5:0] op, output logic [4:0] ph[$]);
        ph = {P_IF, P_ID};
        case (op)
            6'b100011: ph = {ph, P_MEMADR, P_MEMRD, P_WBLW};
            6'b101011: ph = {ph, P_MEMADR, P_MEMWR};
            6'b000000: ph = {ph, P_EXR, P_WBR};
            6'b000100, 6'b000101: ph = {ph, P_BR};
            6'b000010: ph = {ph, P_J};
            6'b000011: ph = {ph, P_JAL};
            6'b001000, 6'b001010: ph = {ph, P_EXI, P_WBI};
            6'b001111: ph = {ph, P_LUI};
            default: ;
        endcase
    endtask

    // Stall counts: -1 picks 0..2 at random.
    task automatic run_inst(input logic [31:0] ins, input int if_stall, input int mem_stall);
        logic [4:0] ph[$];
        int k;
        phases(ins[31:26], ph);
        foreach (ph[i]) begin
            if (ph[i] == P_IF || ph[i] == P_MEMRD || ph[i] == P_MEMWR) begin
                k = (ph[i] == P_IF) ? if_stall : mem_stall;
                if (k < 0) k = $urandom_range(0, 2);
                repeat (k) cyc(ph[i], 1'b0, 1'b1, ins);
                cyc(ph[i], 1'b1, 1'b1, ins);
            end else begin
                cyc(ph[i], 1'($urandom_range(0, 1)), 1'b1, ins);
            end
        end
    endtask

    // Scoreboard monitor: one control word per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        logic [26:0] e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {state, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch,
                 RegDst, MemtoReg, ALUSrcB, PCSource, ALU_operation, MemRead, MemWrite, CPU_MIO};
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL ctrl_word cyc=%0d state=%0d actual=%h expected=%h",
                          cyc_no, state, a, e);
        end
        cyc_no++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  ops[11];
        logic [5:0]  fns[9];
        logic [31:0] ins;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                6'b000011, 6'b001000, 6'b001010, 6'b001111, 6'b111111};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02, 6'h3B};

        // Reset held three cycles: every output zero.
        repeat (3) cyc(P_IF, 1'b1, 1'b0, 32'd0);

        // Directed cases.
        run_inst(32'h00221820, 0, 0);          // add $3,$1,$2
        run_inst(32'h8C850008, 0, 2);          // lw with two MEMRD stalls
        force_z = 1'b1; force_z_val = 1'b1;
        run_inst(32'h10220003, 0, 0);          // beq, zero=1
        run_inst(32'h14220003, 0, 0);          // bne, zero=1
        force_z = 1'b0;
        run_inst(32'h0C000010, 0, 0);          // jal
        run_inst(32'hFC000000, 0, 0);          // undefined opcode
        run_inst(32'hAC850004, 2, 1);          // sw with fetch and write stalls

        // Reset asserted mid-MEMWR: write dropped at once, back to IF after the edge.
        ins = 32'hAC850004;
        cyc(P_IF, 1'b1, 1'b1, ins);
        cyc(P_ID, 1'b1, 1'b1, ins);
        cyc(P_MEMADR, 1'b1, 1'b1, ins);
        cyc(P_MEMWR, 1'b0, 1'b1, ins);
        cyc(P_MEMWR, 1'b0, 1'b0, ins);
        run_inst(32'h3C010005, 0, 0);          // lui straight after reset release

        // Randomised instruction stream.
        for (int n = 0; n < 80; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 10)];
            if (ins[31:26] == 6'b000000 && $urandom_range(0, 3) != 0)
                ins[5:0] = fns[$urandom_range(0, 8)];
            run_inst(ins, -1, -1);
        end

        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
